// File: rtl/tdes_pkg.sv
// Shared TDES datapath constants, channel indices and the DES odd-parity helper.
package tdes_pkg;

   localparam int DES_BLK_W  = 64;
   localparam int TDES_KEY_W = 192;

   // Conventional source channels of the block selector
   localparam int CH_PT  = 0;
   localparam int CH_FB  = 1;
   localparam int CH_IV  = 2;
   localparam int CH_KEY = 3;

   // Parity bit that gives the byte plus this bit an odd number of ones
   function automatic logic odd_par8(input logic [7:0] b);
      return ~(^b);
   endfunction

endpackage

// File: rtl/tdes_blk_mux_if.sv
// Bus bundle of the TDES block selector: source side, output side and status.
// Optional macro TDES_BLK_MUX_PARITY_EN adds the per-byte parity output out_par.
interface tdes_blk_mux_if #(
   parameter int DATA_W = 64,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
);
   logic [SEL_W-1:0]         sel;
   logic [NUM_IN*DATA_W-1:0] in_data;
   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN-1:0]        in_ready;
   logic [DATA_W-1:0]        out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     sel_err;
   logic [15:0]              xfer_cnt;
`ifdef TDES_BLK_MUX_PARITY_EN
   logic [DATA_W/8-1:0]      out_par;

   modport master (
      output sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, sel_err, xfer_cnt, out_par
   );
   modport slave (
      input  sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, sel_err, xfer_cnt, out_par
   );
`else
   modport master (
      output sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, sel_err, xfer_cnt
   );
   modport slave (
      input  sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, sel_err, xfer_cnt
   );
`endif
endinterface

// File: rtl/tdes_skid2.sv
// Generic two-entry valid/ready skid buffer. The main register drives the
// output; the skid register catches one word when the consumer stalls, so
// the producer-side ready depends only on registered state.
module tdes_skid2 #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready
);
   logic [DATA_W-1:0] main_reg;
   logic [DATA_W-1:0] skid_reg;
   logic              main_full_reg;
   logic              skid_full_reg;
   logic              push;
   logic              pop;

   assign in_ready  = !skid_full_reg;
   assign push      = in_valid && !skid_full_reg;
   assign pop       = main_full_reg && out_ready;
   assign out_valid = main_full_reg;
   assign out_data  = main_reg;

   // FIFO-ordered fill/drain of main and skid; skid is only used while main is held
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_reg      <= '0;
         skid_reg      <= '0;
         main_full_reg <= 1'b0;
         skid_full_reg <= 1'b0;
      end else if (!main_full_reg) begin
         if (push) begin
            main_reg      <= in_data;
            main_full_reg <= 1'b1;
         end
      end else if (pop) begin
         if (skid_full_reg) begin
            main_reg      <= skid_reg;
            skid_full_reg <= 1'b0;
         end else if (push) begin
            main_reg <= in_data;
         end else begin
            main_full_reg <= 1'b0;
         end
      end else if (push) begin
         skid_reg      <= in_data;
         skid_full_reg <= 1'b1;
      end
   end

endmodule

// File: rtl/tdes_blk_mux.sv
// Registered N-way block selector for the TDES datapath: select/ready decode,
// a two-entry skid buffer, an output transfer counter and a sticky bad-select flag.
// Optional macro TDES_BLK_MUX_PARITY_EN stores odd byte parity with each block.
module tdes_blk_mux #(
   parameter int DATA_W = 64,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2
) (
   input logic            clk,
   input logic            rst_n,
   tdes_blk_mux_if.slave  bus
);
   import tdes_pkg::*;

`ifdef TDES_BLK_MUX_PARITY_EN
   localparam int PAR_W = DATA_W / 8;
`else
   localparam int PAR_W = 0;
`endif
   localparam int ENT_W = DATA_W + PAR_W;

   logic              sel_ok;
   logic [DATA_W-1:0] sel_data;
   logic              push;
   logic              skid_ready;
   logic [ENT_W-1:0]  push_ent;
   logic [ENT_W-1:0]  head_ent;
   logic              head_valid;
   logic [15:0]       xfer_cnt_reg;
   logic              sel_err_reg;

   // Out-of-range selects accept nothing
   assign sel_ok = {{(32-SEL_W){1'b0}}, bus.sel} < 32'(NUM_IN);

   // Only the selected channel may see ready; held low through reset
   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
      assign bus.in_ready[gi] = rst_n && skid_ready && sel_ok && (bus.sel == SEL_W'(gi));
   end

   assign push = |(bus.in_valid & bus.in_ready);

   // Route the selected channel's block to the capture path
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         if (bus.sel == SEL_W'(k)) begin
            sel_data = bus.in_data[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef TDES_BLK_MUX_PARITY_EN
   logic [PAR_W-1:0] cap_par;

   // Parity is formed at capture so it travels with its block through the skid
   for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
      assign cap_par[gi] = odd_par8(sel_data[gi*8 +: 8]);
   end

   assign push_ent    = {cap_par, sel_data};
   assign bus.out_par = head_ent[DATA_W +: PAR_W];
`else
   assign push_ent = sel_data;
`endif

   tdes_skid2 #(
      .DATA_W (ENT_W)
   ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (push_ent),
      .in_valid  (push),
      .in_ready  (skid_ready),
      .out_data  (head_ent),
      .out_valid (head_valid),
      .out_ready (bus.out_ready)
   );

   assign bus.out_data  = head_ent[DATA_W-1:0];
   assign bus.out_valid = head_valid;
   assign bus.xfer_cnt  = xfer_cnt_reg;
   assign bus.sel_err   = sel_err_reg;

   // Count output transfers (natural 16-bit wrap) and latch any bad select seen with valid data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt_reg <= 16'd0;
         sel_err_reg  <= 1'b0;
      end else begin
         if (head_valid && bus.out_ready) begin
            xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
         end
         if (!sel_ok && (|bus.in_valid)) begin
            sel_err_reg <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tdes_blk_mux.sv
// Self-checking bench for tdes_blk_mux: a queue model of the two-entry buffer
// checked every cycle, plus literal checks for reset, streaming, backpressure,
// select switching, bad select (NUM_IN=3 instance), counter wrap and parity.
module tb_tdes_blk_mux;

   localparam logic [63:0] BASE  = 64'h0123456789ABCDEF;
   localparam logic [63:0] BASE2 = 64'h1000000000000000;

   logic clk;
   logic rst_n;

   tdes_blk_mux_if #(.DATA_W(64), .NUM_IN(4), .SEL_W(2)) bus4 ();
   tdes_blk_mux_if #(.DATA_W(64), .NUM_IN(3), .SEL_W(2)) bus3 ();

   tdes_blk_mux #(.DATA_W(64), .NUM_IN(4), .SEL_W(2)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   tdes_blk_mux #(.DATA_W(64), .NUM_IN(3), .SEL_W(2)) u_dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus3)
   );

   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          done   = 1'b0;
   bit          verbose = 1'b1;
   logic [63:0] mq[$];
   logic [63:0] obs_q[$];
   logic [15:0] m_cnt = 16'd0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_par(input logic [63:0] d);
      logic [7:0] p;
      for (int b = 0; b < 8; b++) begin
         p[b] = ($countones(d[8*b +: 8]) % 2) == 0;
      end
      return p;
   endfunction

   // Compare against the queue model, then advance the model using the inputs
   // that the DUT will sample at the coming rising edge.
   always @(negedge clk) begin
      logic [3:0] exp_ready;
      bit         acc;
      bit         pop;
      if (!done) begin
         exp_ready = (rst_n && mq.size() < 2) ? (4'd1 << bus4.sel) : 4'd0;
         check("in_ready", {60'd0, bus4.in_ready}, {60'd0, exp_ready});
         check("out_valid", {63'd0, bus4.out_valid}, {63'd0, mq.size() > 0});
         if (mq.size() > 0) begin
            check("out_data", bus4.out_data, mq[0]);
`ifdef TDES_BLK_MUX_PARITY_EN
            check("out_par", {56'd0, bus4.out_par}, {56'd0, model_par(mq[0])});
`endif
         end
         check("xfer_cnt", {48'd0, bus4.xfer_cnt}, {48'd0, m_cnt});
         check("sel_err", {63'd0, bus4.sel_err}, 64'd0);

         if (bus4.out_valid && bus4.out_ready) begin
            obs_q.push_back(bus4.out_data);
            if (verbose) $display("xfer cnt=%0d data=%h", m_cnt, bus4.out_data);
         end

         if (!rst_n) begin
            mq.delete();
            m_cnt = 16'd0;
         end else begin
            acc = exp_ready[bus4.sel] && bus4.in_valid[bus4.sel];
            pop = (mq.size() > 0) && bus4.out_ready;
            if (pop) begin
               void'(mq.pop_front());
               m_cnt = m_cnt + 16'd1;
            end
            if (acc) mq.push_back(bus4.in_data[bus4.sel*64 +: 64]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int  idx;
      bit  acc;
      bit  hit;
      int  bad;
      logic [63:0] held;

      rst_n          = 1'b0;
      bus4.sel       = 2'd2;
      bus4.in_valid  = 4'hF;
      bus4.in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus4.out_ready = 1'b0;
      bus3.sel       = 2'd0;
      bus3.in_valid  = 3'b000;
      bus3.in_data   = '0;
      bus3.out_ready = 1'b1;

      // Reset with every source asserting valid
      repeat (3) step();
      @(negedge clk);
      check("rst_out_valid", {63'd0, bus4.out_valid}, 64'd0);
      check("rst_in_ready", {60'd0, bus4.in_ready}, 64'd0);
      check("rst_sel_err", {63'd0, bus4.sel_err}, 64'd0);
      check("rst_xfer_cnt", {48'd0, bus4.xfer_cnt}, 64'd0);
      check("rst_out_data", bus4.out_data, 64'd0);
      step();

      // Streaming on channel 2 at full throughput
      rst_n          = 1'b1;
      bus4.in_valid  = 4'b0100;
      bus4.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus4.in_data[2*64 +: 64] = BASE + 64'(i);
         @(negedge clk);
         check("stream_in_ready", {60'd0, bus4.in_ready}, 64'h4);
         step();
      end
      bus4.in_valid = 4'b0000;
      repeat (3) step();
      @(negedge clk);
      check("stream_count", {48'd0, bus4.xfer_cnt}, 64'd8);
      check("stream_nwords", 64'(obs_q.size()), 64'd8);
      for (int i = 0; i < obs_q.size(); i++) check("stream_order", obs_q[i], BASE + 64'(i));
      step();

      // Backpressure: a well-behaved source that advances only on acceptance
      obs_q.delete();
      idx = 0;
      bus4.in_valid = 4'b0100;
      bus4.in_data[2*64 +: 64] = BASE2;
      held = '0;
      for (int j = 0; j < 12; j++) begin
         bus4.out_ready = !(j >= 2 && j < 6);
         @(negedge clk);
         if (j == 2) held = bus4.out_data;
         if (j == 5) begin
            check("bp_in_ready", {60'd0, bus4.in_ready}, 64'd0);
            check("bp_stable", bus4.out_data, held);
            check("bp_held_word", bus4.out_data, BASE2 + 64'd1);
         end
         acc = bus4.in_ready[2];
         step();
         if (acc) idx++;
         bus4.in_data[2*64 +: 64] = BASE2 + 64'(idx);
      end
      bus4.in_valid  = 4'b0000;
      bus4.out_ready = 1'b1;
      repeat (3) step();
      check("bp_nwords", 64'(obs_q.size()), 64'(idx));
      for (int i = 0; i < obs_q.size(); i++) check("bp_order", obs_q[i], BASE2 + 64'(i));

      // Reset while two words are held discards them
      bus4.in_valid  = 4'b0100;
      bus4.out_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n         = 1'b1;
      bus4.in_valid = 4'b0000;
      @(negedge clk);
      check("midrst_out_valid", {63'd0, bus4.out_valid}, 64'd0);
      step();

      // Alternating select between ch0 and ch1; ch2/ch3 valid but must not be read
      obs_q.delete();
      bus4.in_data  = {64'hDEADBEEF00000003, 64'hDEADBEEF00000002, 64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};
      bus4.in_valid = 4'b1111;
      for (int j = 0; j < 20; j++) begin
         bus4.sel       = 2'(j % 2);
         bus4.out_ready = $urandom_range(0, 3) != 0;
         step();
      end
      bus4.in_valid  = 4'b0000;
      bus4.out_ready = 1'b1;
      repeat (3) step();
      bad = 0;
      foreach (obs_q[i]) if (obs_q[i] != 64'hAAAAAAAAAAAAAAAA && obs_q[i] != 64'h5555555555555555) bad++;
      check("switch_foreign", 64'(bad), 64'd0);
      check("switch_first", obs_q.size() > 0 ? obs_q[0] : 64'd0, 64'hAAAAAAAAAAAAAAAA);

      // Bad select on the three-channel instance
      @(negedge clk);
      check("bad_sel_err_before", {63'd0, bus3.sel_err}, 64'd0);
      step();
      bus3.sel      = 2'd3;
      bus3.in_valid = 3'b111;
      bus3.in_data  = {64'h3, 64'h2, 64'h1};
      @(negedge clk);
      check("bad_in_ready", {61'd0, bus3.in_ready}, 64'd0);
      step();
      @(negedge clk);
      check("bad_out_valid", {63'd0, bus3.out_valid}, 64'd0);
      check("bad_sel_err", {63'd0, bus3.sel_err}, 64'd1);
      step();
      bus3.sel      = 2'd0;
      bus3.in_valid = 3'b000;
      step();
      @(negedge clk);
      check("bad_sel_err_sticky", {63'd0, bus3.sel_err}, 64'd1);
      check("bad_recover_ready", {61'd0, bus3.in_ready}, 64'd1);
      step();

      // Randomized traffic
      for (int j = 0; j < 400; j++) begin
         bus4.sel       = 2'($urandom_range(0, 3));
         bus4.in_valid  = 4'($urandom);
         bus4.in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         bus4.out_ready = $urandom_range(0, 2) != 0;
         step();
      end
      bus4.in_valid  = 4'b0000;
      bus4.out_ready = 1'b1;
      repeat (3) step();

`ifdef TDES_BLK_MUX_PARITY_EN
      // Parity of a single set bit in byte 0
      bus4.sel      = 2'd0;
      bus4.in_valid = 4'b0001;
      bus4.in_data[0 +: 64] = 64'h0000000000000001;
      step();
      bus4.in_valid = 4'b0000;
      @(negedge clk);
      check("par_valid", {63'd0, bus4.out_valid}, 64'd1);
      check("par_value", {56'd0, bus4.out_par}, 64'hFE);
      repeat (2) step();
`endif

      // Counter wrap at full throughput
      verbose        = 1'b0;
      bus4.sel       = 2'd1;
      bus4.in_valid  = 4'b0010;
      bus4.out_ready = 1'b1;
      hit = 1'b0;
      for (int j = 0; j < 70000; j++) begin
         @(negedge clk);
         if (bus4.xfer_cnt == 16'hFFFF && bus4.out_valid) begin
            hit = 1'b1;
            break;
         end
         step();
         bus4.in_data[1*64 +: 64] = 64'(j);
      end
      check("wrap_reached", {63'd0, hit}, 64'd1);
      step();
      @(negedge clk);
      check("wrap_zero", {48'd0, bus4.xfer_cnt}, 64'd0);

      done = 1'b1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
